// File: rtl/pulse_pacer_pkg.sv
// Shared pulse-sync definitions: pacer state encoding,
// default pacing constants and the gap counter sizing helper.
package pulse_pacer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_EMIT = 2'd1;
  localparam state_t S_GAP  = 2'd2;

  localparam int GAP_DEF   = 8;
  localparam int CNT_W_DEF = 4;

  function automatic int gap_w(input int gap);
    int w;
    w = $clog2(gap);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pulse_pacer.sv
// Source-side event pacer: queues single-cycle requests and
// re-emits them as pulses spaced at least GAP cycles apart.
module pulse_pacer
  import pulse_pacer_pkg::*;
#(
  parameter int GAP   = GAP_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt_in,
  input  logic             ovf_clr,
  output logic             pul_out,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             busy,
  output logic             ovf
);

  localparam int GW = gap_w(GAP);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // GAP state lasts GAP-1 cycles: load GAP-2, leave at 0
  localparam logic [GW-1:0] GAP_LD = GW'(GAP - 2);

  state_t          state;
  state_t          state_nx;
  logic [GW-1:0]   gap_cnt;
  logic            inc;
  logic            dec;
  logic            want;
  logic            gap_last;
  logic            drop;

  assign inc      = evt_in;
  assign dec      = (state == S_EMIT);
  assign want     = (pend_cnt != '0) || evt_in;
  assign gap_last = (gap_cnt == '0);
  assign drop     = inc && !dec && (pend_cnt == CNT_MAX);
  assign busy     = (state != S_IDLE) || (pend_cnt != '0);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (want) state_nx = S_EMIT;
      S_EMIT: state_nx = S_GAP;
      S_GAP:  if (gap_last) state_nx = want ? S_EMIT : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      gap_cnt  <= '0;
      pend_cnt <= '0;
      pul_out  <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state   <= state_nx;
      pul_out <= (state_nx == S_EMIT);
      if (state == S_EMIT)
        gap_cnt <= GAP_LD;
      else if (state == S_GAP && !gap_last)
        gap_cnt <= gap_cnt - 1'b1;
      if (inc && !dec && !drop)
        pend_cnt <= pend_cnt + 1'b1;
      else if (dec && !inc)
        pend_cnt <= pend_cnt - 1'b1;
      ovf <= drop || (ovf && !ovf_clr);
    end
  end

endmodule

// File: tb/tb_pulse_pacer.sv
// Self-checking bench for pulse_pacer: vector table, corner
// sequences and random traffic against a timing-rule model.
module tb_pulse_pacer;

  localparam int GAP   = 8;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             evt_in;
  logic             ovf_clr;
  logic             pul_out;
  logic [CNT_W-1:0] pend_cnt;
  logic             busy;
  logic             ovf;

  pulse_pacer #(.GAP(GAP), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .evt_in   (evt_in),
    .ovf_clr  (ovf_clr),
    .pul_out  (pul_out),
    .pend_cnt (pend_cnt),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: a pulse may fire only when GAP cycles have elapsed
  // since the previous one and work is pending or arriving.
  int m_t    = 0;
  int m_last = -1000;
  int m_pend = 0;
  bit m_pul  = 0;
  bit m_ovf  = 0;
  bit m_busy = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0d",
               nm, act, exp, m_t);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit c);
    bit nx_pul;
    bit drop;
    if (r) begin
      m_pend = 0;
      m_pul  = 0;
      m_ovf  = 0;
      m_last = -1000;
      m_busy = 0;
    end else begin
      nx_pul = ((m_t + 1 - m_last) >= GAP) && (m_pend > 0 || e);
      drop   = e && !m_pul && (m_pend == MAXC);
      if (e && !m_pul && !drop)
        m_pend = m_pend + 1;
      else if (m_pul && !e)
        m_pend = m_pend - 1;
      m_ovf = drop || (m_ovf && !c);
      m_pul = nx_pul;
      if (nx_pul) m_last = m_t + 1;
      m_busy = (m_pend != 0) || ((m_t + 1 - m_last) < GAP);
    end
    m_t++;
  endtask

  task automatic cyc(input bit r, input bit e, input bit c);
    rst     = r;
    evt_in  = e;
    ovf_clr = c;
    model_step(r, e, c);
    @(posedge clk);
    #1;
    chk("m_pul",  32'(pul_out),  32'(m_pul));
    chk("m_cnt",  32'(pend_cnt), 32'(m_pend));
    chk("m_busy", 32'(busy),     32'(m_busy));
    chk("m_ovf",  32'(ovf),      32'(m_ovf));
  endtask

  typedef struct {
    bit evt;
    bit clr;
    bit pul;
    int cnt;
    bit busy;
    bit ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit e, input bit c, input bit p,
                     input int n, input bit b, input bit o,
                     input int rep);
    vec_t v;
    v.evt = e; v.clr = c; v.pul = p;
    v.cnt = n; v.busy = b; v.ovf = o;
    for (int i = 0; i < rep; i++) tbl.push_back(v);
  endtask

  initial begin
    int pos[$];
    int npul;
    int rate;

    // single event at N
    add(1, 0, 1, 1, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 7);
    add(0, 0, 0, 0, 0, 0, 1);
    // burst at N, N+1, N+2
    add(1, 0, 1, 1, 1, 0, 1);
    add(1, 0, 0, 1, 1, 0, 1);
    add(1, 0, 0, 2, 1, 0, 1);
    add(0, 0, 0, 2, 1, 0, 5);
    add(0, 0, 1, 2, 1, 0, 1);
    add(0, 0, 0, 1, 1, 0, 7);
    add(0, 0, 1, 1, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 7);
    add(0, 0, 0, 0, 0, 0, 1);

    rst = 1; evt_in = 0; ovf_clr = 0;
    cyc(1, 0, 0);
    cyc(1, 1, 1);
    chk("rst_pul",  32'(pul_out),  0);
    chk("rst_cnt",  32'(pend_cnt), 0);
    chk("rst_busy", 32'(busy),     0);
    chk("rst_ovf",  32'(ovf),      0);

    foreach (tbl[i]) begin
      cyc(0, tbl[i].evt, tbl[i].clr);
      chk("tbl_pul",  32'(pul_out),  32'(tbl[i].pul));
      chk("tbl_cnt",  32'(pend_cnt), 32'(tbl[i].cnt));
      chk("tbl_busy", 32'(busy),     32'(tbl[i].busy));
      chk("tbl_ovf",  32'(ovf),      32'(tbl[i].ovf));
    end

    // overflow: five events into a capacity of three
    cyc(1, 0, 0);
    for (int k = 0; k < 40; k++) begin
      cyc(0, k < 5, 0);
      if (pul_out) pos.push_back(k + 1);
      if (k == 3) begin
        chk("ovf_pre_cnt", 32'(pend_cnt), 3);
        chk("ovf_pre",     32'(ovf),      0);
      end
      if (k == 4) chk("ovf_set", 32'(ovf), 1);
    end
    chk("ovf_npul", 32'(pos.size()), 4);
    if (pos.size() == 4) begin
      chk("ovf_p0", 32'(pos[0]), 1);
      chk("ovf_p1", 32'(pos[1]), 9);
      chk("ovf_p2", 32'(pos[2]), 17);
      chk("ovf_p3", 32'(pos[3]), 25);
    end
    chk("ovf_sticky", 32'(ovf), 1);

    // accept during EMIT at full count, clear races, reset mid-GAP
    cyc(1, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 1, 0);
    for (int k = 4; k < 9; k++) cyc(0, 0, 0);
    chk("fc_emit", 32'(pul_out),  1);
    chk("fc_cnt0", 32'(pend_cnt), 3);
    cyc(0, 1, 0);
    chk("fc_cnt",  32'(pend_cnt), 3);
    chk("fc_ovf",  32'(ovf),      0);
    cyc(0, 1, 0);
    chk("drop_ovf", 32'(ovf), 1);
    cyc(0, 1, 1);
    chk("race_ovf", 32'(ovf), 1);
    cyc(0, 0, 1);
    chk("clr_ovf",  32'(ovf), 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0);
    chk("mg_emit", 32'(pul_out), 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("mg_cnt2", 32'(pend_cnt), 2);
    cyc(1, 0, 0);
    chk("mg_pul",  32'(pul_out),  0);
    chk("mg_cnt",  32'(pend_cnt), 0);
    chk("mg_busy", 32'(busy),     0);
    chk("mg_ovf",  32'(ovf),      0);
    npul = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 0);
      if (pul_out) npul++;
    end
    chk("mg_quiet", 32'(npul), 0);

    // random traffic with varying event density
    rate = 50;
    for (int k = 0; k < 1200; k++) begin
      if (k % 100 == 0) rate = $urandom_range(5, 95);
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 99) < rate,
          $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
